sub24_pipe: RTL and testbench
=============================

Name: sub24_pipe

Overview:
- 24-bit two-stage pipelined subtractor with borrow-in and borrow-out, diff = a - b - bin. It performs the inverse of the 24-bit adder in the SUBARRAY_MAC datapath.
- It uses the same 16+8 split: stage 1 resolves bits [15:0], stage 2 resolves bits [23:16].
- It sits after MAC accumulation and removes offset/bias terms from 24-bit partial sums.
- Valid/ready handshakes on both sides allow it to stall behind a slow consumer.

Parameters:
- none (width fixed at 24; split fixed at 16/8)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand set a/b/bin valid
- in_ready  output  1  block can accept an operand set this cycle
- a  input  24  minuend, unsigned
- b  input  24  subtrahend, unsigned
- bin  input  1  borrow-in
- out_valid  output  1  diff/bout valid
- out_ready  input  1  consumer accepts diff/bout this cycle
- diff  output  24  result, a - b - bin mod 2^24
- bout  output  1  borrow-out; 1 when a < b + bin

Behaviour:
- Interface: one clock; reset is synchronous and active-low; ports are clk and rst_n.
- Reset (rst_n=0 at a rising edge): s1_valid=0, s2_valid=0, out_valid=0, diff=0, bout=0, in_ready=1 on the first cycle after reset.
  - Reset mid-operation discards all in-flight data without emitting it.
- Input transfer: occurs when in_valid && in_ready. Output transfer: occurs when out_valid && out_ready.
- Stage 1 (on transfer into s1):
  - Register d_lo = a[15:0] - b[15:0] - bin (16-bit result) and borrow_mid, the borrow out of bit 15.
  - Register a[23:16] and b[23:16] unchanged.
- Stage 2 (on transfer s1 -> s2):
  - Register diff[15:0] = d_lo.
  - Register {bout, diff[23:16]} = a_hi - b_hi - borrow_mid, computed as a 9-bit subtraction; bout = bit 8 of the 9-bit result.
  - diff and bout are driven directly from the s2 registers.
- Latency: 2 cycles from the input transfer to out_valid, with no stall. Throughput: 1 result per cycle while out_ready=1.
- Flow control:
  - s2_ready = !s2_valid || out_ready.
  - s1_ready = !s1_valid || s2_ready.
  - in_ready = s1_ready, driven combinationally.
  - in_ready must not depend on in_valid.
- Stall: while out_valid=1 and out_ready=0, diff, bout and out_valid hold stable.
  - s1 holds its contents while s2 is stalled.
  - The block accepts at most 2 operand sets beyond the last output transfer; after that in_ready=0.
- Simultaneous events:
  - s2 may accept s1 data in the same cycle it emits its own output (out_ready=1).
  - s1 may accept new input in the same cycle it hands off to s2.
  - Results are never dropped or duplicated.
- Bubbles: if s1_valid=0, s2 loads nothing and s2_valid clears after s2 emits.
- Order: results leave strictly in input order.
- Arithmetic:
  - All subtraction is unsigned modulo 2^24.
  - bout=1 iff {1'b0,a} < {1'b0,b} + bin.
  - For signed interpretation, the consumer derives overflow itself; the block provides no signed flag.

Optional Feature:
- Macro: SUB24_SAT_EN.
- Defined: unsigned floor saturation. When the stage-2 borrow-out is 1, diff registers 24'h000000; bout still reports 1. When bout=0, diff is unchanged.
- Not defined: wrap-around result as specified above.
- Latency and handshake behaviour are identical in both builds.

Test Plan:
- Basic: a=24'h000010, b=24'h000001, bin=0, out_ready=1 -> two cycles later out_valid=1, diff=24'h00000F, bout=0.
- Cross-split borrow: a=24'h010000, b=24'h000001, bin=0 -> diff=24'h00FFFF, bout=0; checks that borrow_mid=1 propagates into the high byte.
- Underflow: a=0, b=0, bin=1 -> diff=24'hFFFFFF, bout=1; with SUB24_SAT_EN -> diff=24'h000000, bout=1.
- Backpressure:
  - Stimulus: stream 5 sets with out_ready=0 for 6 cycles, then 1.
  - Required: in_ready drops after 2 accepted sets; the output stays stable while stalled; all 5 results come out in order with no loss.
- Full throughput: 100 random sets, in_valid=1 and out_ready=1 continuously -> one result per cycle after 2-cycle latency; every result matches the golden model (a-b-bin) mod 2^24 with the correct bout.
- Reset mid-stream: assert rst_n=0 for 1 cycle with both stages valid -> out_valid=0, diff=0, bout=0 the next cycle; the flushed results never appear; a new set after reset has 2-cycle latency.

Source files
------------

// File: rtl/sub24_pipe_if.sv
// Handshake and operand/result bundle for sub24_pipe.
// The master side drives operands and out_ready; the slave side is the subtractor.
interface sub24_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] a;
    logic [23:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] diff;
    logic        bout;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
    );
endinterface

// File: rtl/sub24_pipe.sv
// Two-stage 24-bit subtractor diff = a - b - bin, split 16/8 with valid/ready on both sides.
// Optional macro SUB24_SAT_EN clamps the result to zero whenever the final borrow-out is set.
module sub24_pipe (
    input  logic             clk,
    input  logic             rst_n,
    sub24_pipe_if.slave      bus
);

    logic        s1_valid;
    logic [15:0] s1_d_lo;
    logic        s1_borrow_mid;
    logic [7:0]  s1_a_hi;
    logic [7:0]  s1_b_hi;

    logic        s2_valid;
    logic [23:0] s2_diff;
    logic        s2_bout;

    logic        s2_ready;
    logic        s1_ready;
    logic [16:0] lo_sub;
    logic [8:0]  hi_sub;
    logic [23:0] diff_next;

    // Ready chain depends only on stage occupancy and out_ready, never on in_valid.
    assign s2_ready    = !s2_valid || bus.out_ready;
    assign s1_ready    = !s1_valid || s2_ready;
    assign bus.in_ready = s1_ready;

    // Bit 16 of the widened low subtraction is the borrow out of bit 15.
    assign lo_sub = {1'b0, bus.a[15:0]} - {1'b0, bus.b[15:0]} - {16'b0, bus.bin};
    assign hi_sub = {1'b0, s1_a_hi} - {1'b0, s1_b_hi} - {8'b0, s1_borrow_mid};

`ifdef SUB24_SAT_EN
    assign diff_next = hi_sub[8] ? 24'h000000 : {hi_sub[7:0], s1_d_lo};
`else
    assign diff_next = {hi_sub[7:0], s1_d_lo};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s1_d_lo       <= '0;
            s1_borrow_mid <= 1'b0;
            s1_a_hi       <= '0;
            s1_b_hi       <= '0;
            s2_valid      <= 1'b0;
            s2_diff       <= '0;
            s2_bout       <= 1'b0;
        end else begin
            if (s2_ready) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_diff <= diff_next;
                    s2_bout <= hi_sub[8];
                end
            end
            if (s1_ready) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_d_lo       <= lo_sub[15:0];
                    s1_borrow_mid <= lo_sub[16];
                    s1_a_hi       <= bus.a[23:16];
                    s1_b_hi       <= bus.b[23:16];
                end
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.diff      = s2_diff;
    assign bus.bout      = s2_bout;

endmodule

// File: tb/tb_sub24_pipe.sv
// Self-checking bench for sub24_pipe: directed vectors, backpressure, random streaming and mid-stream reset.
// Expected results come from a plain-integer model of a - b - bin (floored at zero under SUB24_SAT_EN).
module tb_sub24_pipe;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    logic [24:0] exp_q[$];

    sub24_pipe_if bus ();

    sub24_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Result as {bout, diff} straight from integer arithmetic.
    function automatic logic [24:0] model(input logic [23:0] a, input logic [23:0] b, input logic bin);
        longint r;
        logic   bo;
        logic [23:0] d;
        r  = longint'(a) - longint'(b) - longint'(bin);
        bo = (r < 0);
        d  = r[23:0];
`ifdef SUB24_SAT_EN
        if (bo) d = 24'h000000;
`endif
        return {bo, d};
    endfunction

    // One clock: observe handshakes at the negedge, record accepted operands, return just after the posedge.
    task automatic tick(output bit acc, output bit ov, output bit emit, output logic [24:0] obs);
        @(negedge clk);
        acc  = bus.in_valid && bus.in_ready;
        ov   = bus.out_valid;
        emit = bus.out_valid && bus.out_ready;
        obs  = {bus.bout, bus.diff};
        if (acc) exp_q.push_back(model(bus.a, bus.b, bus.bin));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit acc, ov, emit;
        logic [24:0] obs;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a = '0; bus.b = '0; bus.bin = 1'b0;
        tick(acc, ov, emit, obs);
        tick(acc, ov, emit, obs);
        rst_n = 1'b1;
        exp_q.delete();
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %0b, required 0", bus.out_valid);
        else n_pass++;
        n_checks++;
        if (bus.diff !== 24'h0) $display("[TB] FAIL reset_diff: got %h, required 000000", bus.diff);
        else n_pass++;
        n_checks++;
        if (bus.bout !== 1'b0) $display("[TB] FAIL reset_bout: got %0b, required 0", bus.bout);
        else n_pass++;
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %0b, required 1", bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [23:0] va[3];
        logic [23:0] vb[3];
        logic        vbin[3];
        logic [24:0] vexp[3];
        bit acc, ov, emit;
        logic [24:0] obs, got;
        int lat;
        va[0] = 24'h000010; vb[0] = 24'h000001; vbin[0] = 1'b0; vexp[0] = {1'b0, 24'h00000F};
        va[1] = 24'h010000; vb[1] = 24'h000001; vbin[1] = 1'b0; vexp[1] = {1'b0, 24'h00FFFF};
`ifdef SUB24_SAT_EN
        va[2] = 24'h000000; vb[2] = 24'h000000; vbin[2] = 1'b1; vexp[2] = {1'b1, 24'h000000};
`else
        va[2] = 24'h000000; vb[2] = 24'h000000; vbin[2] = 1'b1; vexp[2] = {1'b1, 24'hFFFFFF};
`endif
        bus.out_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            bus.a = va[v]; bus.b = vb[v]; bus.bin = vbin[v];
            bus.in_valid = 1'b1;
            tick(acc, ov, emit, obs);
            bus.in_valid = 1'b0;
            n_checks++;
            if (acc !== 1'b1) $display("[TB] FAIL directed%0d_accept: got %0b, required 1", v, acc);
            else n_pass++;
            lat = -1;
            got = '0;
            for (int t = 1; t <= 4; t++) begin
                tick(acc, ov, emit, obs);
                if (emit && lat < 0) begin
                    lat = t;
                    got = obs;
                end
            end
            n_checks++;
            if (lat !== 2) $display("[TB] FAIL directed%0d_latency: got %0d, required 2", v, lat);
            else n_pass++;
            n_checks++;
            if (got !== vexp[v]) $display("[TB] FAIL directed%0d_result: got bout=%0b diff=%h, required bout=%0b diff=%h",
                                          v, got[24], got[23:0], vexp[v][24], vexp[v][23:0]);
            else n_pass++;
            exp_q.delete();
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] pa[5];
        logic [23:0] pb[5];
        logic        pbin[5];
        bit acc, ov, emit;
        logic [24:0] obs, held, want;
        bit have_held;
        int idx, emitted, cyc;
        for (int i = 0; i < 5; i++) begin
            pa[i] = 24'($urandom); pb[i] = 24'($urandom); pbin[i] = 1'($urandom);
        end
        idx = 0; emitted = 0; have_held = 0; held = '0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            bus.in_valid = (idx < 5);
            bus.a = pa[idx]; bus.b = pb[idx]; bus.bin = pbin[idx];
            tick(acc, ov, emit, obs);
            if (acc) idx++;
            if (ov && !have_held) begin
                have_held = 1;
                held = obs;
                want = exp_q[0];
                n_checks++;
                if (held !== want) $display("[TB] FAIL bp_stalled_value: got %h, required %h", held, want);
                else n_pass++;
            end else if (have_held) begin
                n_checks++;
                if (!ov || obs !== held) $display("[TB] FAIL bp_stable: got valid=%0b %h, required valid=1 %h", ov, obs, held);
                else n_pass++;
            end
        end
        n_checks++;
        if (idx !== 2) $display("[TB] FAIL bp_accept_count: got %0d, required 2", idx);
        else n_pass++;
        n_checks++;
        if (bus.in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready: got %0b, required 0", bus.in_ready);
        else n_pass++;
        bus.out_ready = 1'b1;
        cyc = 0;
        while (emitted < 5 && cyc < 30) begin
            bus.in_valid = (idx < 5);
            bus.a = pa[idx]; bus.b = pb[idx]; bus.bin = pbin[idx];
            tick(acc, ov, emit, obs);
            if (acc) idx++;
            if (emit) begin
                emitted++;
                n_checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL bp_extra_output: got %h, required none", obs);
                else begin
                    want = exp_q.pop_front();
                    if (obs !== want) $display("[TB] FAIL bp_drain_result: got %h, required %h", obs, want);
                    else n_pass++;
                end
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (emitted !== 5 || exp_q.size() != 0)
            $display("[TB] FAIL bp_total: got %0d outputs with %0d pending, required 5 with 0 pending", emitted, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_throughput();
        bit acc, ov, emit;
        logic [24:0] obs, want;
        int emitted;
        emitted = 0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 102; k++) begin
            bus.in_valid = (k < 100);
            bus.a   = 24'($urandom);
            bus.b   = (k % 10 == 3) ? bus.a : 24'($urandom);
            bus.bin = 1'($urandom);
            tick(acc, ov, emit, obs);
            n_checks++;
            if (acc !== (k < 100) || emit !== (k >= 2))
                $display("[TB] FAIL tp_flow_k%0d: got acc=%0b emit=%0b, required acc=%0b emit=%0b", k, acc, emit, k < 100, k >= 2);
            else n_pass++;
            if (emit) begin
                emitted++;
                n_checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL tp_extra_output: got %h, required none", obs);
                else begin
                    want = exp_q.pop_front();
                    if (obs !== want) $display("[TB] FAIL tp_result_k%0d: got %h, required %h", k, obs, want);
                    else n_pass++;
                end
            end
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (emitted !== 100) $display("[TB] FAIL tp_count: got %0d, required 100", emitted);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit acc, ov, emit;
        logic [24:0] obs, want;
        int n_out, first_t;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.a = 24'($urandom); bus.b = 24'($urandom); bus.bin = 1'($urandom);
            tick(acc, ov, emit, obs);
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        tick(acc, ov, emit, obs);
        n_checks++;
        if (ov !== 1'b1) $display("[TB] FAIL rm_full_before_reset: got out_valid=%0b, required 1", ov);
        else n_pass++;
        exp_q.delete();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.diff !== 24'h0 || bus.bout !== 1'b0)
            $display("[TB] FAIL rm_after_reset: got valid=%0b diff=%h bout=%0b, required 0 000000 0", bus.out_valid, bus.diff, bus.bout);
        else n_pass++;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a = 24'h123456; bus.b = 24'h654321; bus.bin = 1'b1;
        want = model(bus.a, bus.b, bus.bin);
        n_out = 0; first_t = -1;
        for (int t = 0; t < 6; t++) begin
            tick(acc, ov, emit, obs);
            bus.in_valid = 1'b0;
            if (emit) begin
                n_out++;
                if (first_t < 0) first_t = t;
                n_checks++;
                if (obs !== want) $display("[TB] FAIL rm_new_result: got %h, required %h", obs, want);
                else n_pass++;
            end
        end
        n_checks++;
        if (n_out !== 1 || first_t !== 2)
            $display("[TB] FAIL rm_latency: got %0d outputs first at tick %0d, required 1 at tick 2", n_out, first_t);
        else n_pass++;
        exp_q.delete();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.bin = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_backpressure();
        test_throughput();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
